display_scheduler: RTL and testbench
====================================

// Module: display_scheduler
// PURPOSE
//  Controller that sequences and shares the 4-digit multiplexed seven-segment display.
//  - Generates the one-cycle digit-scan enable for the display driver.
//  - Arbitrates the four BCD digit slots between the running-timer source and the user-edit source.
//  - Blinks the digit under edit, and flashes the whole display on alarm until acknowledged.
//  - Sits between the timer core / button logic and the display driver (clk_enable, digit0..3).
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  SCAN_HZ     500          scan-enable pulse rate; one digit advance per pulse
//  BLINK_HZ    2            full blink period rate; phase toggles at 2*BLINK_HZ
//  BLANK_CODE  4'hF         BCD code rendered by the decoder as all segments off
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  time_digits     in   16  running-timer digits, [3:0]=digit0 ... [15:12]=digit3
//  edit_digits     in   16  user-edit digits, same packing
//  edit_req        in   1   level: user is in set mode
//  edit_sel        in   2   index of the digit being edited (0..3)
//  alarm           in   1   level from timer core: countdown expired
//  ack             in   1   one-cycle pulse: user acknowledges alarm
//  scan_enable     out  1   one-cycle pulse to display driver clk_enable
//  digit0..digit3  out  4   each: digits presented to the display driver (registered)
//  mode            out  2   current state: 00 RUN, 01 EDIT, 10 ALARM
// BEHAVIOUR
//  Reset (reset=1 at a clk edge):
//   - state RUN; scan and blink counters 0; blink phase ON.
//   - scan_enable=0; digit0..3=BLANK_CODE; mode=00; alarm edge register 0.
//  Scan tick:
//   - SCAN_DIV = CLK_HZ/SCAN_HZ; counter runs 0..SCAN_DIV-1 and wraps.
//   - scan_enable=1 for exactly the cycle where count==SCAN_DIV-1.
//   - First pulse falls in the SCAN_DIV-th cycle after reset is released.
//   - Free-running; unaffected by mode changes.
//  Blink phase:
//   - BLINK_DIV = CLK_HZ/(2*BLINK_HZ); phase toggles when the counter wraps.
//   - Counter clears to 0 and phase forces ON on every state change.
//  FSM (priority ALARM > EDIT > RUN; evaluated every cycle):
//   - RUN   -> ALARM on alarm rising edge (alarm=1 and prior-cycle alarm=0);
//             else -> EDIT if edit_req=1.
//   - EDIT  -> ALARM on alarm rising edge; else -> RUN if edit_req=0.
//   - ALARM -> RUN on ack=1; edit_req is ignored in ALARM.
//   - alarm still high after ack does not re-enter ALARM; a new rising edge is required.
//   - ack outside ALARM has no effect.
//   - alarm edge and ack in the same cycle while in ALARM: exit to RUN
//     (that edge cannot exist while alarm is held; it is a new event only if alarm had dropped).
//  Digit outputs (registered, 1-cycle latency from inputs/state):
//   - RUN:   digitN = time_digits[N].
//   - EDIT:  digitN = edit_digits[N]; digit edit_sel = BLANK_CODE when phase OFF.
//            edit_sel change takes effect next cycle and does not restart blink.
//   - ALARM: phase ON -> time_digits; phase OFF -> all BLANK_CODE.
//  mode is registered alongside the digits and matches the state that produced them.
//  Reset mid-operation: returns to the reset values on the next clk edge, regardless of state.
// STRUCTURE
//  - Include file display_defs.vh: mode encodings MODE_RUN/MODE_EDIT/MODE_ALARM, default BLANK_CODE.
//  - Sub-module tick_divider #(DIV): synchronous-reset modulo counter with wrap pulse and clear input.
//    Instantiate once for scan (clear tied 0) and once for blink (clear = state change).
//  - FSM, alarm edge register and output mux live in the top module.
// TESTING  (CLK_HZ=1000, SCAN_HZ=100, BLINK_HZ=25 -> SCAN_DIV=10, BLINK_DIV=20)
//  - Reset release -> scan_enable pulses at cycles 10,20,30 after release, 1 cycle wide;
//    digits BLANK_CODE until first output register update.
//  - RUN, time_digits=16'h1234 -> next cycle digit3..0 = 1,2,3,4; mode=00.
//  - edit_req=1, edit_digits=16'h0530, edit_sel=1 -> mode=01; digit1=3 for 20 cycles,
//    then F for 20 cycles, repeating; other digits steady.
//  - alarm 0->1 during EDIT -> mode=10; all digits show time value 20 cycles, blank 20 cycles;
//    ack pulse -> mode=00 next cycle with alarm still 1; no re-entry until alarm drops and rises.
//  - reset asserted while in ALARM -> next cycle mode=00, digits F, scan counter restarted.
//  - ack in RUN and edit_req in ALARM -> no state change; scan_enable cadence unbroken through all mode changes.

Source files
------------

// File: rtl/display_scheduler_pkg.sv
// display_scheduler_pkg
//   Shared definitions for the display scheduler slice:
//   - mode_e      : scheduler state, also the encoding presented on the mode output
//   - DEFAULT_BLANK_CODE : BCD code the decoder renders as all segments off
//   - blank_digit : replaces one 4-bit digit of a packed 4-digit word
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_EDIT  = 2'b01,
        MODE_ALARM = 2'b10
    } mode_e;

    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

    // Returns d with digit number sel overwritten by code.
    function automatic logic [15:0] blank_digit(input logic [15:0] d,
                                                input logic [1:0]  sel,
                                                input logic [3:0]  code);
        logic [15:0] r;
        r = d;
        r[{sel, 2'b00} +: 4] = code;
        return r;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if
//   Bundles the scheduler's source-side inputs and display-side outputs.
//   Signalling: there is no valid/ready handshake on this bus. edit_req and
//   alarm are levels sampled every clock; ack is a single-cycle pulse;
//   scan_enable is a single-cycle pulse; digit0..3 and mode are registered
//   and change only on clk edges.
//   master : the environment (timer core, button logic, display driver)
//   slave  : the scheduler itself
interface display_scheduler_if;
    import display_scheduler_pkg::*;

    logic [15:0] time_digits;   // [3:0]=digit0 ... [15:12]=digit3
    logic [15:0] edit_digits;   // same packing
    logic        edit_req;
    logic [1:0]  edit_sel;
    logic        alarm;
    logic        ack;
    logic        scan_enable;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    mode_e       mode;

    modport master (
        output time_digits, edit_digits, edit_req, edit_sel, alarm, ack,
        input  scan_enable, digit0, digit1, digit2, digit3, mode
    );

    modport slave (
        input  time_digits, edit_digits, edit_req, edit_sel, alarm, ack,
        output scan_enable, digit0, digit1, digit2, digit3, mode
    );

endinterface

// File: rtl/display_scheduler_tick_divider.sv
// tick_divider
//   Modulo-DIV counter. wrap is high for the single cycle in which the count
//   sits at DIV-1; the count then returns to 0. clear forces the count to 0
//   on the next edge, like reset.
//   Ports: clk, reset (sync, active high), clear (sync), wrap (out).
module tick_divider #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic wrap
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign wrap = (count == LAST);

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
//   Shares the 4-digit multiplexed seven-segment display between the running
//   timer and the user-edit source, generates the digit-scan enable, blinks
//   the digit under edit and flashes the display on alarm until acknowledged.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : display_scheduler_if.slave (sources in, scan/digits/mode out)
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          SCAN_HZ    = 500,
    parameter int          BLINK_HZ   = 2,
    parameter logic [3:0]  BLANK_CODE = DEFAULT_BLANK_CODE
) (
    input  logic                 clk,
    input  logic                 reset,
    display_scheduler_if.slave   bus
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

    mode_e       state;
    mode_e       state_next;
    logic        alarm_q;
    logic        alarm_rise;
    logic        state_change;
    logic        scan_wrap;
    logic        blink_wrap;
    logic        phase_on;
    logic [15:0] digits_next;
    logic [15:0] digits_q;
    mode_e       mode_q;

    // Free-running scan tick; never cleared by mode changes.
    tick_divider #(.DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .wrap  (scan_wrap)
    );

    // Blink timebase restarts whenever the state changes so every new mode
    // begins with a full ON half-period.
    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .reset (reset),
        .clear (state_change),
        .wrap  (blink_wrap)
    );

    assign alarm_rise   = bus.alarm && !alarm_q;
    assign state_change = (state_next != state);

    // Next-state logic: ALARM > EDIT > RUN. Only a fresh rising edge of alarm
    // enters ALARM, so a level still held after ack does not re-trigger.
    always_comb begin
        state_next = state;
        unique case (state)
            MODE_RUN: begin
                if (alarm_rise)        state_next = MODE_ALARM;
                else if (bus.edit_req) state_next = MODE_EDIT;
            end
            MODE_EDIT: begin
                if (alarm_rise)         state_next = MODE_ALARM;
                else if (!bus.edit_req) state_next = MODE_RUN;
            end
            MODE_ALARM: begin
                if (bus.ack) state_next = MODE_RUN;
            end
            default: state_next = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MODE_RUN;
            alarm_q  <= 1'b0;
            phase_on <= 1'b1;
        end else begin
            state   <= state_next;
            alarm_q <= bus.alarm;
            if (state_change) begin
                phase_on <= 1'b1;
            end else if (blink_wrap) begin
                phase_on <= !phase_on;
            end
        end
    end

    // Digit source selection for the current (registered) state and phase.
    always_comb begin
        digits_next = bus.time_digits;
        unique case (state)
            MODE_EDIT: begin
                if (phase_on) digits_next = bus.edit_digits;
                else          digits_next = blank_digit(bus.edit_digits, bus.edit_sel, BLANK_CODE);
            end
            MODE_ALARM: begin
                if (!phase_on) digits_next = {4{BLANK_CODE}};
            end
            default: digits_next = bus.time_digits;
        endcase
    end

    // mode is registered with the digits so it always names the state that
    // produced the digits currently on display.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= {4{BLANK_CODE}};
            mode_q   <= MODE_RUN;
        end else begin
            digits_q <= digits_next;
            mode_q   <= state;
        end
    end

    assign bus.scan_enable = scan_wrap;
    assign bus.digit0      = digits_q[3:0];
    assign bus.digit1      = digits_q[7:4];
    assign bus.digit2      = digits_q[11:8];
    assign bus.digit3      = digits_q[15:12];
    assign bus.mode        = mode_q;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;
  import display_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_scheduler_if bus();

  display_scheduler #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(25), .BLANK_CODE(4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int SCAN_DIV  = 10;
  localparam int BLINK_DIV = 20;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Abstract view: a mode number, cycles since the last mode change (blink
  // phase is ON for the even BLINK_DIV-sized windows), cycles since reset.
  int          m_state = 0;      // 0 run, 1 edit, 2 alarm
  logic        m_alarm_prev = 1'b0;
  int          m_since = 0;
  int          m_ticks = 0;
  logic [17:0] exp_q[$];         // {mode, digit3..digit0}

  task automatic model_edge();
    logic        ph;
    logic        rise;
    logic [15:0] d;
    int          nxt;
    if (reset) begin
      m_state = 0; m_since = 0; m_ticks = 0; m_alarm_prev = 1'b0;
      exp_q.push_back({2'b00, 16'hFFFF});
      return;
    end
    ph = ((m_since / BLINK_DIV) % 2) == 0;
    case (m_state)
      0: d = bus.time_digits;
      1: begin
        d = bus.edit_digits;
        if (!ph) d[int'(bus.edit_sel) * 4 +: 4] = 4'hF;
      end
      default: d = ph ? bus.time_digits : 16'hFFFF;
    endcase
    exp_q.push_back({m_state[1:0], d});
    rise = bus.alarm && !m_alarm_prev;
    nxt = m_state;
    case (m_state)
      0: if (rise) nxt = 2; else if (bus.edit_req) nxt = 1;
      1: if (rise) nxt = 2; else if (!bus.edit_req) nxt = 0;
      default: if (bus.ack) nxt = 0;
    endcase
    if (nxt != m_state) m_since = 0; else m_since++;
    m_state = nxt;
    m_ticks++;
    m_alarm_prev = bus.alarm;
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check();
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      cmp("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    cmp("scan", 32'(bus.scan_enable), 32'((m_ticks % SCAN_DIV) == SCAN_DIV - 1));
    cmp("digits", {16'h0, bus.digit3, bus.digit2, bus.digit1, bus.digit0}, {16'h0, e[15:0]});
    cmp("mode", 32'(bus.mode), {30'h0, e[17:16]});
  endtask

  // ---------------- driver ----------------
  // Inputs change only at the negedge; one posedge per call, then sample.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check();
  endtask

  typedef struct packed {
    logic        rst;
    logic [15:0] td;
    logic [15:0] ed;
    logic        req;
    logic [1:0]  sel;
    logic        al;
    logic        ack;
    logic [7:0]  n;
    logic [1:0]  mode;
    logic [15:0] dig;
  } vec_t;

  vec_t vecs[$];
  int   pulses[$];

  initial begin
    bus.time_digits = 16'h0;
    bus.edit_digits = 16'h0;
    bus.edit_req    = 1'b0;
    bus.edit_sel    = 2'd0;
    bus.alarm       = 1'b0;
    bus.ack         = 1'b0;

    // rst, time, edit, req, sel, alarm, ack, cycles, exp mode, exp digits
    vecs.push_back('{1'b1, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd2,  2'b00, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1,  2'b00, 16'h1234});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b0, 1'b0, 8'd2,  2'b01, 16'h0530});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b0, 1'b0, 8'd20, 2'b01, 16'h05F0});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b0, 1'b0, 8'd20, 2'b01, 16'h0530});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b1, 1'b0, 8'd2,  2'b10, 16'h1234});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b1, 1'b0, 8'd20, 2'b10, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b1, 2'd1, 1'b1, 1'b1, 8'd1,  2'b10, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h1234, 16'h0530, 1'b0, 2'd1, 1'b1, 1'b0, 8'd3,  2'b00, 16'h1234});
    vecs.push_back('{1'b0, 16'h9876, 16'h0530, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1,  2'b00, 16'h9876});
    vecs.push_back('{1'b0, 16'h9876, 16'h0530, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1,  2'b00, 16'h9876});
    vecs.push_back('{1'b0, 16'h9876, 16'h0530, 1'b0, 2'd1, 1'b1, 1'b0, 8'd2,  2'b10, 16'h9876});
    vecs.push_back('{1'b1, 16'h9876, 16'h0530, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1,  2'b00, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h4321, 16'h0530, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1,  2'b00, 16'h4321});

    // ---- table-driven directed vectors ----
    foreach (vecs[i]) begin
      reset           = vecs[i].rst;
      bus.time_digits = vecs[i].td;
      bus.edit_digits = vecs[i].ed;
      bus.edit_req    = vecs[i].req;
      bus.edit_sel    = vecs[i].sel;
      bus.alarm       = vecs[i].al;
      bus.ack         = vecs[i].ack;
      for (int k = 0; k < int'(vecs[i].n); k++) step();
      cmp($sformatf("vec%0d_mode", i), 32'(bus.mode), {30'h0, vecs[i].mode});
      cmp($sformatf("vec%0d_digits", i),
          {16'h0, bus.digit3, bus.digit2, bus.digit1, bus.digit0}, {16'h0, vecs[i].dig});
    end

    // ---- scan cadence after reset release: pulses at cycles 10, 20, 30 ----
    bus.alarm = 1'b0; bus.ack = 1'b0; bus.edit_req = 1'b0;
    reset = 1'b1;
    step();
    if (bus.scan_enable) pulses.push_back(1);
    reset = 1'b0;
    for (int c = 2; c <= 35; c++) begin
      // mode traffic during the window must not disturb the cadence
      bus.edit_req = (c >= 5 && c < 15);
      bus.alarm    = (c >= 18);
      bus.ack      = (c == 25);
      step();
      if (bus.scan_enable) pulses.push_back(c);
    end
    cmp("scan_pulse_count", 32'(pulses.size()), 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (p < pulses.size()) cmp($sformatf("scan_pulse%0d", p), 32'(pulses[p]), 32'((p + 1) * 10));
      else                   cmp($sformatf("scan_pulse%0d", p), 32'd0, 32'((p + 1) * 10));
    end

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0)  bus.time_digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0)  bus.edit_digits = 16'($urandom);
      if ($urandom_range(0, 39) == 0) bus.edit_req    = !bus.edit_req;
      if ($urandom_range(0, 29) == 0) bus.edit_sel    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.alarm       = !bus.alarm;
      bus.ack = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
